// File: rtl/sram_pkg.sv
// Shared types and defaults for the frame-buffer SRAM arbiter.
package sram_pkg;

   localparam int unsigned ADDR_W_DEF      = 20;
   localparam int unsigned DATA_W_DEF      = 16;
   localparam int unsigned WFIFO_DEPTH_DEF = 8;
   localparam int unsigned MAX_RUN_DEF     = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_WS,
      ST_WP,
      ST_WH
   } state_e;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic ub_n;
      logic lb_n;
   } strobe_t;

   // Strobe pattern driven while the FSM sits in the given state.
   function automatic strobe_t strobes_for(input state_e s);
      strobe_t st;
      st = '1;
      case (s)
         ST_RD0, ST_RD1: st = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0};
         ST_WS, ST_WH:   st = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0};
         ST_WP:          st = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, ub_n: 1'b0, lb_n: 1'b0};
         default:        st = '1;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; push while full is discarded
// even when a pop happens on the same edge.
module sync_fifo #(
   parameter int unsigned WIDTH = 36,
   parameter int unsigned DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               din,
   output logic [WIDTH-1:0]               dout,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: display reads take priority, buffered writes are
// forced through after MAX_RUN consecutive reads so write latency stays bounded.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned WFIFO_DEPTH = WFIFO_DEPTH_DEF,
   parameter int unsigned MAX_RUN     = MAX_RUN_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              select,
   output logic [ADDR_W-1:0] readAddress,
   output logic [ADDR_W-1:0] writeAddress,
   input  logic [DATA_W-1:0] sram_dq_in,
   output logic [DATA_W-1:0] sram_dq_out,
   output logic              sram_dq_oe,
   output logic              CE_N,
   output logic              OE_N,
   output logic              WE_N,
   output logic              UB_N,
   output logic              LB_N
);

   localparam int unsigned FIFO_W = ADDR_W + DATA_W;
   localparam int unsigned CNT_W  = $clog2(WFIFO_DEPTH + 1);
   localparam int unsigned RUN_W  = $clog2(MAX_RUN + 1);

   state_e            state_q, state_d;
   logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
   logic              select_q, select_d;
   logic [ADDR_W-1:0] read_address_q, read_address_d;
   logic [ADDR_W-1:0] write_address_q, write_address_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] dq_out_q, dq_out_d;
   logic              dq_oe_q, dq_oe_d;
   strobe_t           strobe_q, strobe_d;

   logic [FIFO_W-1:0] fifo_head;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              decide, wr_grant, rd_grant;

   sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (WFIFO_DEPTH)
   ) u_wfifo (
      .clk   (Clk),
      .rst   (Reset),
      .push  (wr_valid),
      .pop   (wr_grant),
      .din   ({wr_addr, wr_data}),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign wr_ready = !fifo_full;
   assign decide   = (state_q == ST_IDLE) || (state_q == ST_RD1) || (state_q == ST_WH);
   assign wr_grant = decide && !fifo_empty && (!rd_req || (run_cnt_q == RUN_W'(MAX_RUN)));
   assign rd_grant = decide && !wr_grant && rd_req;

   always_comb begin
      state_d         = state_q;
      run_cnt_d       = run_cnt_q;
      read_address_d  = read_address_q;
      write_address_d = write_address_q;
      dq_out_d        = dq_out_q;
      rd_data_d       = rd_data_q;
      rd_valid_d      = (state_q == ST_RD1);

      case (state_q)
         ST_RD0:  state_d = ST_RD1;
         ST_WS:   state_d = ST_WP;
         ST_WP:   state_d = ST_WH;
         default: begin
            if (wr_grant)      state_d = ST_WS;
            else if (rd_grant) state_d = ST_RD0;
            else               state_d = ST_IDLE;
         end
      endcase

      if (rd_grant) read_address_d = rd_addr;
      if (wr_grant) {write_address_d, dq_out_d} = fifo_head;
      if (state_q == ST_RD1) rd_data_d = sram_dq_in;

      // Run length only matters while a write is waiting.
      if (fifo_count == '0)
         run_cnt_d = '0;
      else if (wr_grant)
         run_cnt_d = '0;
      else if (rd_grant && (run_cnt_q != RUN_W'(MAX_RUN)))
         run_cnt_d = run_cnt_q + RUN_W'(1);

      select_d = (state_d == ST_WS) || (state_d == ST_WP) || (state_d == ST_WH);
      dq_oe_d  = select_d;
      strobe_d = strobes_for(state_d);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q         <= ST_IDLE;
         run_cnt_q       <= '0;
         select_q        <= 1'b0;
         read_address_q  <= '0;
         write_address_q <= '0;
         rd_data_q       <= '0;
         rd_valid_q      <= 1'b0;
         dq_out_q        <= '0;
         dq_oe_q         <= 1'b0;
         strobe_q        <= '1;
      end else begin
         state_q         <= state_d;
         run_cnt_q       <= run_cnt_d;
         select_q        <= select_d;
         read_address_q  <= read_address_d;
         write_address_q <= write_address_d;
         rd_data_q       <= rd_data_d;
         rd_valid_q      <= rd_valid_d;
         dq_out_q        <= dq_out_d;
         dq_oe_q         <= dq_oe_d;
         strobe_q        <= strobe_d;
      end
   end

   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;
   assign select       = select_q;
   assign readAddress  = read_address_q;
   assign writeAddress = write_address_q;
   assign sram_dq_out  = dq_out_q;
   assign sram_dq_oe   = dq_oe_q;
   assign CE_N         = strobe_q.ce_n;
   assign OE_N         = strobe_q.oe_n;
   assign WE_N         = strobe_q.we_n;
   assign UB_N         = strobe_q.ub_n;
   assign LB_N         = strobe_q.lb_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM pin model plus a transaction-level reference
// (access kind + phase counter, write queue, reference memory).
module tb_sram_arbiter;

   localparam int unsigned AW    = 20;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned MAXR  = 4;
   localparam int K_NONE = 0, K_RD = 1, K_WR = 2;

   logic          Clk, Reset;
   logic          rd_req, rd_valid, wr_valid, wr_ready, select, sram_dq_oe;
   logic [AW-1:0] rd_addr, wr_addr, readAddress, writeAddress;
   logic [DW-1:0] rd_data, wr_data, sram_dq_in, sram_dq_out;
   logic          CE_N, OE_N, WE_N, UB_N, LB_N;

   sram_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .WFIFO_DEPTH (DEPTH),
      .MAX_RUN     (MAXR)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .select       (select),
      .readAddress  (readAddress),
      .writeAddress (writeAddress),
      .sram_dq_in   (sram_dq_in),
      .sram_dq_out  (sram_dq_out),
      .sram_dq_oe   (sram_dq_oe),
      .CE_N         (CE_N),
      .OE_N         (OE_N),
      .WE_N         (WE_N),
      .UB_N         (UB_N),
      .LB_N         (LB_N)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Unwritten locations read back a fixed address-derived pattern.
   function automatic logic [15:0] dflt(input logic [9:0] a);
      logic [15:0] t;
      if (a == 10'h345) return 16'hBEEF;
      t = {6'd0, a} * 16'd37;
      return t ^ 16'h5A3C;
   endfunction

   // SRAM pin model, addressed through the select mux.
   logic [15:0] phys [0:1023];
   bit          wrote [0:1023];
   logic [9:0]  sram_idx;
   assign sram_idx   = select ? writeAddress[9:0] : readAddress[9:0];
   assign sram_dq_in = wrote[sram_idx] ? phys[sram_idx] : dflt(sram_idx);
   always @(posedge Clk) begin
      if (!CE_N && !WE_N) begin
         phys[sram_idx]  <= sram_dq_out;
         wrote[sram_idx] <= 1'b1;
      end
   end

   // Reference model state.
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   wr_t           wq[$];
   logic [15:0]   refm [0:1023];
   bit            rwrote [0:1023];
   int            kind, phase, run;
   logic          m_valid;
   logic [DW-1:0] m_rdata, m_wd;
   logic [AW-1:0] m_ra, m_wa;
   int            n_tests, n_fail;

   function automatic logic [15:0] ref_rd(input logic [9:0] a);
      return rwrote[a] ? refm[a] : dflt(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task model_reset();
      wq.delete();
      kind = K_NONE; phase = 0; run = 0;
      m_valid = 1'b0; m_rdata = '0; m_ra = '0; m_wa = '0; m_wd = '0;
   endtask

   task automatic check_all();
      logic ce, oe, we, sel;
      case (kind)
         K_RD:    begin ce = 0; oe = 0; we = 1; sel = 0; end
         K_WR:    begin ce = 0; oe = 1; we = (phase == 1) ? 1'b0 : 1'b1; sel = 1; end
         default: begin ce = 1; oe = 1; we = 1; sel = 0; end
      endcase
      check("rd_valid", rd_valid, m_valid);
      check("rd_data", rd_data, m_rdata);
      check("select", select, sel);
      check("readAddress", readAddress, m_ra);
      check("writeAddress", writeAddress, m_wa);
      check("sram_dq_out", sram_dq_out, m_wd);
      check("sram_dq_oe", sram_dq_oe, sel);
      check("CE_N", CE_N, ce);
      check("OE_N", OE_N, oe);
      check("WE_N", WE_N, we);
      check("UB_N", UB_N, ce);
      check("LB_N", LB_N, ce);
      check("wr_ready", wr_ready, wq.size() < DEPTH);
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      bit  pending, full_pre, decide;
      wr_t e;
      @(posedge Clk);
      pending  = (wq.size() != 0);
      full_pre = (wq.size() >= DEPTH);
      m_valid  = (kind == K_RD && phase == 1);
      if (m_valid) m_rdata = ref_rd(m_ra[9:0]);
      decide = (kind == K_NONE) || (kind == K_RD && phase == 1) || (kind == K_WR && phase == 2);
      if (decide) begin
         if (pending && (!rd_req || run == MAXR)) begin
            e = wq.pop_front();
            m_wa = e.a; m_wd = e.d;
            refm[e.a[9:0]] = e.d; rwrote[e.a[9:0]] = 1'b1;
            kind = K_WR; phase = 0; run = 0;
         end else if (rd_req) begin
            m_ra = rd_addr; kind = K_RD; phase = 0;
            if (run < MAXR) run++;
         end else begin
            kind = K_NONE; phase = 0;
         end
      end else begin
         phase++;
      end
      if (!pending) run = 0;
      if (wr_valid && !full_pre) wq.push_back('{a: wr_addr, d: wr_data});
      #1;
      check_all();
   endtask

   initial begin
      int we_cnt, oe_cnt, sel_cnt;
      n_tests = 0; n_fail = 0;
      rd_req = 0; rd_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
      model_reset();

      // Reset state, before any clock edge.
      Reset = 1'b1;
      #1 check_all();
      #21 Reset = 1'b0;
      repeat (2) step();

      // Single read of 0x12345; requester drops rd_req once the access started.
      rd_req = 1; rd_addr = 20'h12345;
      step();
      check("rd_grant_addr", readAddress, 20'h12345);
      rd_req = 0;
      step();
      check("rd1_oe", OE_N, 1'b0);
      step();
      check("rd_valid_cycle3", rd_valid, 1'b1);
      check("rd_data_beef", rd_data, 16'hBEEF);
      step();
      check("rd_valid_pulse", rd_valid, 1'b0);

      // Single write from idle.
      wr_valid = 1; wr_addr = 20'h00010; wr_data = 16'hA5A5;
      step();
      wr_valid = 0;
      we_cnt = 0; oe_cnt = 0; sel_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (WE_N == 1'b0) we_cnt++;
         if (sram_dq_oe) oe_cnt++;
         if (select) sel_cnt++;
      end
      check("wr_we_cycles", we_cnt, 1);
      check("wr_oe_cycles", oe_cnt, 3);
      check("wr_sel_cycles", sel_cnt, 3);
      check("wr_mem", phys[10'h010], 16'hA5A5);

      // Priority: write pending and rd_req at the same decision, run count 0.
      rd_req = 1; rd_addr = 20'h00777;
      step();
      rd_req = 0; wr_valid = 1; wr_addr = 20'h00020; wr_data = 16'h1234;
      step();
      wr_valid = 0; rd_req = 1; rd_addr = 20'h00020;
      step();
      check("prio_read_first", select, 1'b0);
      rd_req = 0;
      step();
      step();
      check("prio_write_next", select, 1'b1);
      repeat (4) step();

      // FIFO fill while reads are requested continuously.
      rd_req = 1; rd_addr = 20'h00300;
      we_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         wr_valid = 1; wr_addr = 20'h00100 + 20'(i); wr_data = 16'hC000 + 16'(i);
         step();
         if (WE_N == 1'b0) we_cnt++;
         if (i == 7) check("fill_wr_ready_low", wr_ready, 1'b0);
      end
      wr_valid = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (WE_N == 1'b0) we_cnt++;
      end
      rd_req = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (WE_N == 1'b0) we_cnt++;
      end
      check("fill_we_pulses", we_cnt, 8);
      check("fill_9th_dropped", wrote[10'h108], 1'b0);
      check("fill_8th_written", phys[10'h107], 16'hC007);

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         if (!rd_req) begin
            if ($urandom_range(0, 99) < 40) begin
               rd_req = 1; rd_addr = 20'($urandom);
            end
         end else if ((m_valid && $urandom_range(0, 99) < 70) || $urandom_range(0, 99) < 5) begin
            rd_req = 0;
         end
         wr_valid = ($urandom_range(0, 99) < 30);
         wr_addr  = 20'($urandom);
         wr_data  = 16'($urandom);
         step();
      end
      rd_req = 0; wr_valid = 0;
      repeat (40) step();

      // Reset in the middle of a write pulse.
      wr_valid = 1; wr_addr = 20'h00055; wr_data = 16'h0F0F;
      step();
      wr_valid = 0;
      for (int i = 0; i < 10 && WE_N !== 1'b0; i++) step();
      check("reach_wp", WE_N, 1'b0);
      #3 Reset = 1'b1;
      model_reset();
      #1 check_all();
      check("rst_wp_wr_ready", wr_ready, 1'b1);
      #2 Reset = 1'b0;
      repeat (3) step();

      // Reset during the second read phase: no rd_valid afterwards.
      rd_req = 1; rd_addr = 20'h00abc;
      step();
      rd_req = 0;
      step();
      #3 Reset = 1'b1;
      model_reset();
      #1 check_all();
      #2 Reset = 1'b0;
      step();
      check("rst_rd_no_valid", rd_valid, 1'b0);
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
